// File: rtl/hangman_game_ctrl_pkg.sv
// Shared definitions for the hangman game controller and its letter matcher.
// State codes match the encoding the VGA renderer decodes from game_state.
package hangman_game_ctrl_pkg;

    localparam int WORD_LEN  = 6;
    localparam int LETTER_W  = 5;
    localparam int ALPHA     = 26;
    localparam int MAX_WRONG = 6;
    localparam int WORD_W    = WORD_LEN * LETTER_W;
    localparam int CNT_W     = 3;

    typedef enum logic [1:0] {
        ST_START    = 2'd0,
        ST_INGAME   = 2'd1,
        ST_WINGAME  = 2'd2,
        ST_LOSTGAME = 2'd3
    } game_state_e;

    // ACCEPT: waiting for a guess; EVAL: judging the captured guess.
    typedef enum logic {
        PH_ACCEPT = 1'b0,
        PH_EVAL   = 1'b1
    } phase_e;

endpackage

// File: rtl/hangman_game_ctrl_letter_match.sv
// Combinational letter matcher.
//   word         : latched word, letter 0 at the MSBs
//   letter       : guessed letter code
//   next_mask    : mask as it will be after this guess
//   hit          : letter equals at least one word slot
//   all_revealed : every word slot's letter is set in next_mask
module hangman_game_ctrl_letter_match
    import hangman_game_ctrl_pkg::*;
(
    input  logic [WORD_W-1:0]   word,
    input  logic [LETTER_W-1:0] letter,
    input  logic [ALPHA-1:0]    next_mask,
    output logic                hit,
    output logic                all_revealed
);

    logic [WORD_LEN-1:0] slot_hit;
    logic [WORD_LEN-1:0] slot_rev;

    for (genvar i = 0; i < WORD_LEN; i++) begin : g_slot
        logic [LETTER_W-1:0] code;
        assign code        = word[(WORD_LEN-1-i)*LETTER_W +: LETTER_W];
        assign slot_hit[i] = (code == letter);
        // A slot holding a non-letter code can never be revealed.
        assign slot_rev[i] = (code < LETTER_W'(ALPHA)) && next_mask[code];
    end

    assign hit          = |slot_hit;
    assign all_revealed = &slot_rev;

endmodule

// File: rtl/hangman_game_ctrl.sv
// Hangman game controller: latches the word on start, takes letter guesses over
// a valid/ready handshake and tracks revealed mask, wrong count and game state.
//   clk, resetn            : clock, asynchronous active-low reset
//   start, word_in         : begin a new game (ignored while INGAME)
//   guess_valid/letter     : guess request; guess_ready accepts it
//   game_state, word, mask : renderer-facing game status
//   wrong_count            : wrong guesses so far, saturating at MAX_WRONG
//   guess_hit/miss/repeat  : one-cycle result pulse, 2 cycles after acceptance
module hangman_game_ctrl
    import hangman_game_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [WORD_W-1:0]   word_in,
    input  logic                guess_valid,
    input  logic [LETTER_W-1:0] guess_letter,
    output logic                guess_ready,
    output logic [1:0]          game_state,
    output logic [WORD_W-1:0]   word,
    output logic [ALPHA-1:0]    mask,
    output logic [CNT_W-1:0]    wrong_count,
    output logic                guess_hit,
    output logic                guess_miss,
    output logic                guess_repeat
);

    game_state_e         state_q, state_n;
    phase_e              phase_q, phase_n;
    logic [LETTER_W-1:0] g_reg, g_n;
    logic [WORD_W-1:0]   word_n;
    logic [ALPHA-1:0]    mask_n;
    logic [CNT_W-1:0]    cnt_n;
    logic                ready_n, hit_n, miss_n, rep_n;

    // Evaluation of the captured guess against the current mask/word.
    logic                g_valid, already, lm_hit, lm_all;
    logic [ALPHA-1:0]    g_onehot, eval_mask;
    logic [CNT_W-1:0]    cnt_inc;

    assign g_valid   = g_reg < LETTER_W'(ALPHA);
    assign g_onehot  = g_valid ? (ALPHA'(1) << g_reg) : '0;
    assign already   = |(mask & g_onehot);
    assign eval_mask = mask | g_onehot;
    assign cnt_inc   = (wrong_count < CNT_W'(MAX_WRONG)) ? wrong_count + CNT_W'(1) : wrong_count;

    hangman_game_ctrl_letter_match u_letter_match (
        .word         (word),
        .letter       (g_reg),
        .next_mask    (eval_mask),
        .hit          (lm_hit),
        .all_revealed (lm_all)
    );

    assign game_state = state_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_START;
            phase_q      <= PH_ACCEPT;
            g_reg        <= '0;
            word         <= '0;
            mask         <= '0;
            wrong_count  <= '0;
            guess_ready  <= 1'b0;
            guess_hit    <= 1'b0;
            guess_miss   <= 1'b0;
            guess_repeat <= 1'b0;
        end else begin
            state_q      <= state_n;
            phase_q      <= phase_n;
            g_reg        <= g_n;
            word         <= word_n;
            mask         <= mask_n;
            wrong_count  <= cnt_n;
            guess_ready  <= ready_n;
            guess_hit    <= hit_n;
            guess_miss   <= miss_n;
            guess_repeat <= rep_n;
        end
    end

    always_comb begin
        state_n = state_q;
        phase_n = phase_q;
        g_n     = g_reg;
        word_n  = word;
        mask_n  = mask;
        cnt_n   = wrong_count;
        hit_n   = 1'b0;
        miss_n  = 1'b0;
        rep_n   = 1'b0;

        if (state_q != ST_INGAME) begin
            if (start) begin
                word_n  = word_in;
                mask_n  = '0;
                cnt_n   = '0;
                state_n = ST_INGAME;
                phase_n = PH_ACCEPT;
            end
        end else if (phase_q == PH_ACCEPT) begin
            if (guess_valid && guess_ready) begin
                g_n     = guess_letter;
                phase_n = PH_EVAL;
            end
        end else begin
            phase_n = PH_ACCEPT;
            if (!g_valid || already) begin
                rep_n = 1'b1;
            end else begin
                mask_n = eval_mask;
                if (lm_hit) begin
                    hit_n = 1'b1;
                end else begin
                    miss_n = 1'b1;
                    cnt_n  = cnt_inc;
                end
                // End-of-game is judged on the post-guess mask and count.
                if (lm_all)
                    state_n = ST_WINGAME;
                else if (cnt_n == CNT_W'(MAX_WRONG))
                    state_n = ST_LOSTGAME;
            end
        end

        ready_n = (state_n == ST_INGAME) && (phase_n == PH_ACCEPT);
    end

endmodule

// File: tb/tb_hangman_game_ctrl.sv
// Bench for hangman_game_ctrl: directed table of guesses, hand-written corner
// sequences, and randomized play checked every cycle against a game model.
module tb_hangman_game_ctrl;
    import hangman_game_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn, start, guess_valid;
    logic [29:0] word_in;
    logic [4:0]  guess_letter;
    logic        guess_ready, guess_hit, guess_miss, guess_repeat;
    logic [1:0]  game_state;
    logic [29:0] word;
    logic [25:0] mask;
    logic [2:0]  wrong_count;

    hangman_game_ctrl dut (
        .clk(clk), .resetn(resetn), .start(start), .word_in(word_in),
        .guess_valid(guess_valid), .guess_letter(guess_letter),
        .guess_ready(guess_ready), .game_state(game_state), .word(word),
        .mask(mask), .wrong_count(wrong_count), .guess_hit(guess_hit),
        .guess_miss(guess_miss), .guess_repeat(guess_repeat)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- game model ----------------
    int       m_state;
    int       m_word[6];
    bit [25:0] m_mask;
    int       m_cnt;
    bit       m_ready, m_hit, m_miss, m_rep;
    int       m_pend;     // captured guess waiting to be judged, -1 if none

    function automatic void model_reset();
        m_state = 0; m_mask = '0; m_cnt = 0; m_ready = 0;
        m_hit = 0; m_miss = 0; m_rep = 0; m_pend = -1;
        for (int i = 0; i < 6; i++) m_word[i] = 0;
    endfunction

    function automatic logic [29:0] model_word();
        logic [29:0] w = '0;
        for (int i = 0; i < 6; i++) w[(5-i)*5 +: 5] = 5'(m_word[i]);
        return w;
    endfunction

    function automatic void judge(input int c);
        bit found, won;
        if (c >= 26 || m_mask[c]) begin
            m_rep = 1;
        end else begin
            m_mask[c] = 1;
            found = 0;
            for (int i = 0; i < 6; i++) if (m_word[i] == c) found = 1;
            if (found) m_hit = 1;
            else begin
                m_miss = 1;
                if (m_cnt < 6) m_cnt++;
            end
            won = 1;
            for (int i = 0; i < 6; i++)
                if (m_word[i] >= 26 || !m_mask[m_word[i]]) won = 0;
            if (won) m_state = 2;
            else if (m_cnt == 6) m_state = 3;
        end
    endfunction

    function automatic void model_clock();
        m_hit = 0; m_miss = 0; m_rep = 0;
        if (m_state != 1) begin
            if (start) begin
                for (int i = 0; i < 6; i++) m_word[i] = int'(word_in[(5-i)*5 +: 5]);
                m_mask = '0; m_cnt = 0; m_state = 1; m_ready = 1; m_pend = -1;
            end
        end else if (m_pend >= 0) begin
            judge(m_pend);
            m_pend = -1;
            m_ready = (m_state == 1);
        end else if (guess_valid && m_ready) begin
            m_pend = int'(guess_letter);
            m_ready = 0;
        end
    endfunction

    task automatic check_model();
        check("state", game_state, m_state);
        check("word", word, model_word());
        check("mask", mask, m_mask);
        check("count", wrong_count, m_cnt);
        check("ready", guess_ready, m_ready);
        check("hit", guess_hit, m_hit);
        check("miss", guess_miss, m_miss);
        check("repeat", guess_repeat, m_rep);
    endtask

    // One clock: drive inputs, advance model at the edge, compare at negedge.
    task automatic step(input logic s, input logic [29:0] w, input logic v, input logic [4:0] l);
        start = s; word_in = w; guess_valid = v; guess_letter = l;
        @(posedge clk);
        if (!resetn) model_reset(); else model_clock();
        @(negedge clk);
        check_model();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          new_game;
        logic [29:0] w;
        logic [4:0]  letter;
        bit          hit, miss, rep;
        int          cnt, st;
    } vec_t;

    localparam logic [29:0] APPLES = {5'd0, 5'd15, 5'd15, 5'd11, 5'd4, 5'd18};
    vec_t vecs[$];

    task automatic do_guess(input logic [4:0] l);
        int k = 0;
        while (!guess_ready && k < 10) begin
            step(0, '0, 0, '0);
            k++;
        end
        check("ready_timeout", guess_ready, 1'b1);
        step(0, '0, 1, l);
        check("ready_in_eval", guess_ready, 1'b0);
        step(0, '0, 0, '0);
    endtask

    int reps;

    initial begin
        resetn = 0; start = 0; word_in = '0; guess_valid = 0; guess_letter = '0;
        model_reset();
        #12;
        check("rst_state", game_state, 0);
        check("rst_ready", guess_ready, 0);
        check("rst_word", word, 0);
        @(negedge clk);
        resetn = 1;
        step(0, '0, 1, 5'd3);   // guess outside INGAME is ignored
        check("idle_ready", guess_ready, 0);

        vecs.push_back('{1, APPLES, 5'd15, 1, 0, 0, 0, 1});
        vecs.push_back('{0, '0,     5'd15, 0, 0, 1, 0, 1});
        vecs.push_back('{0, '0,     5'd27, 0, 0, 1, 0, 1});
        vecs.push_back('{0, '0,     5'd0,  1, 0, 0, 0, 1});
        vecs.push_back('{0, '0,     5'd11, 1, 0, 0, 0, 1});
        vecs.push_back('{0, '0,     5'd4,  1, 0, 0, 0, 1});
        vecs.push_back('{0, '0,     5'd18, 1, 0, 0, 0, 2});
        vecs.push_back('{1, APPLES, 5'd25, 0, 1, 0, 1, 1});
        vecs.push_back('{0, '0,     5'd24, 0, 1, 0, 2, 1});
        vecs.push_back('{0, '0,     5'd23, 0, 1, 0, 3, 1});
        vecs.push_back('{0, '0,     5'd22, 0, 1, 0, 4, 1});
        vecs.push_back('{0, '0,     5'd21, 0, 1, 0, 5, 1});
        vecs.push_back('{0, '0,     5'd20, 0, 1, 0, 6, 3});

        foreach (vecs[i]) begin
            if (vecs[i].new_game) begin
                step(1, vecs[i].w, 0, '0);
                check("start_word", word, vecs[i].w);
                check("start_state", game_state, 1);
                check("start_ready", guess_ready, 1);
            end
            do_guess(vecs[i].letter);
            check("t_hit", guess_hit, vecs[i].hit);
            check("t_miss", guess_miss, vecs[i].miss);
            check("t_rep", guess_repeat, vecs[i].rep);
            check("t_cnt", wrong_count, vecs[i].cnt);
            check("t_state", game_state, vecs[i].st);
            if (vecs[i].letter < 26) check("t_mask", mask[vecs[i].letter], 1);
        end

        // Lost: ready low and guesses ignored, display held.
        check("lost_ready", guess_ready, 0);
        repeat (3) step(0, '0, 1, 5'd0);
        check("lost_mask0", mask[0], 0);
        check("lost_state", game_state, 3);
        check("lost_cnt", wrong_count, 6);

        // Held-valid invalid code: one capture per ready cycle.
        step(1, APPLES, 0, '0);
        reps = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, '0, 1, 5'd27);
            reps += int'(guess_repeat);
        end
        check("held_valid_reps", reps, 2);
        check("invalid_mask", mask, 0);
        step(0, '0, 0, '0);
        step(1, 30'h3FFF_FFFF, 0, '0);   // start while INGAME ignored
        check("ingame_start_word", word, APPLES);
        check("ingame_start_state", game_state, 1);

        // Async reset in the middle of EVAL.
        step(0, '0, 1, 5'd15);
        guess_valid = 0;
        #2 resetn = 0;
        #1;
        check("arst_state", game_state, 0);
        check("arst_mask", mask, 0);
        check("arst_cnt", wrong_count, 0);
        check("arst_ready", guess_ready, 0);
        check("arst_hit", guess_hit, 0);
        model_reset();
        @(negedge clk);
        step(0, '0, 0, '0);
        resetn = 1;
        step(0, '0, 0, '0);

        // Randomized play against the model.
        for (int g = 0; g < 30; g++) begin
            int base;
            logic [29:0] w;
            base = $urandom_range(0, 18);
            for (int i = 0; i < 6; i++) w[(5-i)*5 +: 5] = 5'(base + $urandom_range(0, 7));
            step(1, w, 0, '0);
            for (int c = 0; c < 60; c++) begin
                logic [4:0] l;
                logic [29:0] w2;
                if ($urandom_range(0, 9) < 7) l = 5'(base + $urandom_range(0, 9));
                else l = 5'($urandom_range(0, 31));
                for (int i = 0; i < 6; i++) w2[(5-i)*5 +: 5] = 5'($urandom_range(0, 25));
                step(($urandom_range(0, 39) == 0), w2, 1'($urandom_range(0, 1)), l);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
